// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_ctrl_pkg: shared constants and FSM encoding for the pipeline control |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pipe_ctrl_pkg;

  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
  localparam int          HOLD_TIMEOUT_DEF = 256;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_JPEND = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sat_counter: up-counter with increment enable that sticks at all-ones     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_ctrl: pipeline hold/flush control, deferred jumps, bus-hold timeout   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int HOLD_TIMEOUT = HOLD_TIMEOUT_DEF,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             jump_en_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             bus_hold_i,
  input  logic             div_busy_i,
  input  logic             ex_is_load_i,
  input  logic             ex_reg_we_i,
  input  logic [4:0]       ex_reg_waddr_i,
  input  logic [4:0]       id_rs1_raddr_i,
  input  logic [4:0]       id_rs2_raddr_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  output logic             jump_en_o,
  output logic [31:0]      jump_addr_o,
  output logic             hold_pc_o,
  output logic             hold_if_id_o,
  output logic             hold_id_ex_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             hold_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int                HCNT_W    = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(HOLD_TIMEOUT);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HOLD_TIMEOUT - 1);

  state_e              state_q,     state_d;
  logic [31:0]         pend_addr_q, pend_addr_d;
  logic [HCNT_W-1:0]   hold_cnt_q,  hold_cnt_d;
  logic                timeout_q,   timeout_d;
  logic                load_use;

  assign load_use = ex_is_load_i && ex_reg_we_i && (ex_reg_waddr_i != 5'd0) &&
                    ((id_rs1_used_i && (id_rs1_raddr_i == ex_reg_waddr_i)) ||
                     (id_rs2_used_i && (id_rs2_raddr_i == ex_reg_waddr_i)));

  // Outputs are forced quiet while reset is asserted. The HOLD release cycle
  // behaves exactly like RUN, so only JPEND needs its own branch.
  always_comb begin
    jump_en_o     = 1'b0;
    jump_addr_o   = ZERO_WORD;
    hold_pc_o     = 1'b0;
    hold_if_id_o  = 1'b0;
    hold_id_ex_o  = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    if (rst_n) begin
      if (bus_hold_i) begin
        hold_pc_o    = 1'b1;
        hold_if_id_o = 1'b1;
        hold_id_ex_o = 1'b1;
      end else if (state_q == ST_JPEND) begin
        jump_en_o     = 1'b1;
        jump_addr_o   = pend_addr_q;
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
      end else if (jump_en_i) begin
        jump_en_o     = 1'b1;
        jump_addr_o   = jump_addr_i;
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
      end else if (load_use) begin
        hold_pc_o     = 1'b1;
        hold_if_id_o  = 1'b1;
        flush_id_ex_o = 1'b1;
      end else if (div_busy_i) begin
        hold_pc_o    = 1'b1;
        hold_if_id_o = 1'b1;
        hold_id_ex_o = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    case (state_q)
      ST_RUN: begin
        if (bus_hold_i) begin
          if (jump_en_i) begin
            state_d     = ST_JPEND;
            pend_addr_d = jump_addr_i;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!bus_hold_i) begin
          state_d = ST_RUN;
        end else if (jump_en_i) begin
          state_d     = ST_JPEND;
          pend_addr_d = jump_addr_i;
        end
      end
      ST_JPEND: begin
        if (!bus_hold_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // The flag arms while the counter sits one below the limit, so it becomes
  // visible right after the HOLD_TIMEOUT-th consecutive hold cycle.
  always_comb begin
    hold_cnt_d = '0;
    if (bus_hold_i) begin
      hold_cnt_d = (hold_cnt_q == HCNT_MAX) ? hold_cnt_q : hold_cnt_q + HCNT_W'(1);
    end
    timeout_d = timeout_q || (bus_hold_i && (hold_cnt_q == HCNT_LAST));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      pend_addr_q <= ZERO_WORD;
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      hold_cnt_q  <= hold_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign hold_timeout_o = timeout_q;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (hold_pc_o),
    .count_o (stall_cnt_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipe_ctrl: directed + random stimulus against a behavioural model      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pipe_ctrl;

  localparam int HT       = 4;
  localparam int CW       = 8;
  localparam int STALL_MX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        bus_hold_i;
  logic        div_busy_i;
  logic        ex_is_load_i;
  logic        ex_reg_we_i;
  logic [4:0]  ex_reg_waddr_i;
  logic [4:0]  id_rs1_raddr_i;
  logic [4:0]  id_rs2_raddr_i;
  logic        id_rs1_used_i;
  logic        id_rs2_used_i;
  logic        jump_en_o;
  logic [31:0] jump_addr_o;
  logic        hold_pc_o;
  logic        hold_if_id_o;
  logic        hold_id_ex_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic        hold_timeout_o;
  logic [CW-1:0] stall_cnt_o;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .HOLD_TIMEOUT (HT),
    .CNT_W        (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .jump_en_i      (jump_en_i),
    .jump_addr_i    (jump_addr_i),
    .bus_hold_i     (bus_hold_i),
    .div_busy_i     (div_busy_i),
    .ex_is_load_i   (ex_is_load_i),
    .ex_reg_we_i    (ex_reg_we_i),
    .ex_reg_waddr_i (ex_reg_waddr_i),
    .id_rs1_raddr_i (id_rs1_raddr_i),
    .id_rs2_raddr_i (id_rs2_raddr_i),
    .id_rs1_used_i  (id_rs1_used_i),
    .id_rs2_used_i  (id_rs2_used_i),
    .jump_en_o      (jump_en_o),
    .jump_addr_o    (jump_addr_o),
    .hold_pc_o      (hold_pc_o),
    .hold_if_id_o   (hold_if_id_o),
    .hold_id_ex_o   (hold_id_ex_o),
    .flush_if_id_o  (flush_if_id_o),
    .flush_id_ex_o  (flush_id_ex_o),
    .hold_timeout_o (hold_timeout_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a pending-jump slot, the length of the current bus-hold
  // run, the sticky timeout flag and the stall total.
  bit          m_pend;
  logic [31:0] m_pend_addr;
  int          m_hold_run;
  bit          m_tmo;
  int          m_stall;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr();
    rst_n          = 1'b1;
    jump_en_i      = 1'b0;
    jump_addr_i    = 32'h0;
    bus_hold_i     = 1'b0;
    div_busy_i     = 1'b0;
    ex_is_load_i   = 1'b0;
    ex_reg_we_i    = 1'b0;
    ex_reg_waddr_i = 5'd0;
    id_rs1_raddr_i = 5'd0;
    id_rs2_raddr_i = 5'd0;
    id_rs1_used_i  = 1'b0;
    id_rs2_used_i  = 1'b0;
  endtask

  // Called at a negedge with inputs already driven; checks, advances the
  // model across the next posedge and returns at the following negedge.
  task automatic step();
    logic        e_jen;
    logic [31:0] e_jaddr;
    logic [2:0]  e_hold;
    logic [1:0]  e_flush;
    bit          lu;
    #1;
    if (!rst_n) begin
      m_pend = 0; m_pend_addr = 32'h0; m_hold_run = 0; m_tmo = 0; m_stall = 0;
    end
    e_jen = 1'b0; e_jaddr = 32'h0; e_hold = 3'b000; e_flush = 2'b00;
    lu = ex_is_load_i && ex_reg_we_i && (ex_reg_waddr_i != 0) &&
         ((id_rs1_used_i && id_rs1_raddr_i == ex_reg_waddr_i) ||
          (id_rs2_used_i && id_rs2_raddr_i == ex_reg_waddr_i));
    if (!rst_n) begin
      e_hold = 3'b000;
    end else if (bus_hold_i) begin
      e_hold = 3'b111;
    end else if (m_pend) begin
      e_jen = 1'b1; e_jaddr = m_pend_addr; e_flush = 2'b11;
    end else if (jump_en_i) begin
      e_jen = 1'b1; e_jaddr = jump_addr_i; e_flush = 2'b11;
    end else if (lu) begin
      e_hold = 3'b110; e_flush = 2'b01;
    end else if (div_busy_i) begin
      e_hold = 3'b111;
    end
    check("jump_en", jump_en_o, e_jen);
    check("jump_addr", jump_addr_o, e_jaddr);
    check("holds", {hold_pc_o, hold_if_id_o, hold_id_ex_o}, e_hold);
    check("flushes", {flush_if_id_o, flush_id_ex_o}, e_flush);
    check("timeout", hold_timeout_o, m_tmo);
    check("stall_cnt", stall_cnt_o, m_stall);
    if (rst_n) begin
      if (e_hold[2] && m_stall < STALL_MX) m_stall++;
      if (bus_hold_i) begin
        m_hold_run++;
        if (m_hold_run >= HT) m_tmo = 1;
        if (jump_en_i && !m_pend) begin
          m_pend = 1; m_pend_addr = jump_addr_i;
        end
      end else begin
        m_hold_run = 0;
        m_pend     = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  int hold_left;

  initial begin
    clr();
    rst_n = 1'b0;
    @(negedge clk);
    step();

    // Plain jump in RUN
    clr(); jump_en_i = 1'b1; jump_addr_i = 32'h0000_0100; step();

    // Jump arriving under bus hold, released afterwards
    clr(); bus_hold_i = 1'b1; jump_en_i = 1'b1; jump_addr_i = 32'h0000_0200;
    repeat (3) step();
    clr(); step(); step();

    // Load-use: hit, waddr=0 miss, jump overriding
    clr(); ex_is_load_i = 1'b1; ex_reg_we_i = 1'b1; ex_reg_waddr_i = 5'd5;
    id_rs2_raddr_i = 5'd5; id_rs2_used_i = 1'b1; step();
    clr(); step();
    clr(); ex_is_load_i = 1'b1; ex_reg_we_i = 1'b1; ex_reg_waddr_i = 5'd0;
    id_rs2_raddr_i = 5'd0; id_rs2_used_i = 1'b1; step();
    clr(); ex_is_load_i = 1'b1; ex_reg_we_i = 1'b1; ex_reg_waddr_i = 5'd5;
    id_rs1_raddr_i = 5'd5; id_rs1_used_i = 1'b1; jump_en_i = 1'b1;
    jump_addr_i = 32'h0000_0300; step();

    // Divide busy for 4 cycles
    clr(); div_busy_i = 1'b1; repeat (4) step();
    clr(); step();

    // Timeout: 3 hold cycles do not trip it, 4 do, and it is sticky
    clr(); bus_hold_i = 1'b1; repeat (3) step();
    clr(); step();
    check("tmo_after_3", hold_timeout_o, 1'b0);
    bus_hold_i = 1'b1; repeat (4) step();
    clr(); step(); step();
    check("tmo_sticky", hold_timeout_o, 1'b1);

    // Reset in the middle of a pending jump
    clr(); bus_hold_i = 1'b1; jump_en_i = 1'b1; jump_addr_i = 32'h0000_0400; step();
    rst_n = 1'b0; step();
    clr(); step(); step();

    // Stall counter saturation
    clr(); div_busy_i = 1'b1; repeat (STALL_MX + 10) step();
    check("stall_sat", stall_cnt_o, STALL_MX);
    clr(); step();

    // Random traffic
    hold_left = 0;
    for (int i = 0; i < 3000; i++) begin
      clr();
      if (hold_left == 0 && $urandom_range(0, 9) == 0) hold_left = $urandom_range(1, 6);
      if (hold_left > 0) begin
        bus_hold_i = 1'b1;
        hold_left--;
      end
      jump_en_i      = ($urandom_range(0, 4) == 0);
      jump_addr_i    = $urandom();
      div_busy_i     = ($urandom_range(0, 3) == 0);
      ex_is_load_i   = $urandom_range(0, 1) == 1;
      ex_reg_we_i    = $urandom_range(0, 3) != 0;
      ex_reg_waddr_i = 5'($urandom_range(0, 3));
      id_rs1_raddr_i = 5'($urandom_range(0, 3));
      id_rs2_raddr_i = 5'($urandom_range(0, 3));
      id_rs1_used_i  = $urandom_range(0, 1) == 1;
      id_rs2_used_i  = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 299) == 0) begin
        rst_n     = 1'b0;
        hold_left = 0;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
